// File: rtl/lpc_rd_pkg.sv
// Shared types and constants for the LPC lag-pair memory reader.
// Used by lpc_mem_reader and lpc_rd_skid.
package lpc_rd_pkg;

  localparam int L_WINDOW_DEFAULT = 240;
  localparam int ADDR_W           = 8;
  localparam int SAMPLE_W         = 16;
  localparam int CALC_W           = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } rd_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] a;
    logic [SAMPLE_W-1:0] b;
    logic                last;
  } rd_pair_t;

  // Address arithmetic runs one bit wider than the read port so n+k never wraps.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [CALC_W-1:0] v);
    return v[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/lpc_rd_skid.sv
// One-pair holding register between the read pipeline and the pair output.
// Instantiated by lpc_mem_reader only when LPC_READER_STALL_EN is defined.
module lpc_rd_skid
  import lpc_rd_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     in_valid,
  input  rd_pair_t in_pair,
  input  logic     out_ready,
  output logic     out_valid,
  output rd_pair_t out_pair,
  output logic     hold_valid
);

  rd_pair_t hold_pair;

  // NOTE: the data registers are reset too, not only the valid flags,
  // so Sample_A/Sample_B read back as zero straight after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pair   <= '0;
      hold_valid <= 1'b0;
      hold_pair  <= '0;
    end else if (!out_valid || out_ready) begin
      if (hold_valid) begin
        out_valid <= 1'b1;
        out_pair  <= hold_pair;
        if (in_valid) begin
          hold_pair <= in_pair;
        end else begin
          hold_valid <= 1'b0;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_pair <= in_pair;
        end
      end
    end else if (in_valid) begin
      // Output is stalled: park the arriving pair; the reader never lets two arrive.
      hold_valid <= 1'b1;
      hold_pair  <= in_pair;
    end
  end

endmodule

// File: rtl/lpc_mem_reader.sv
// Streams (x[n], x[n+k]) sample pairs from a synchronous buffer for one lag pass.
// Optional output back-pressure (Out_Ready) is enabled by defining LPC_READER_STALL_EN.
module lpc_mem_reader
  import lpc_rd_pkg::*;
#(
  parameter int L_WINDOW = L_WINDOW_DEFAULT,
  parameter int LAG_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Start,
  input  logic [LAG_W-1:0]    Lag,
  output logic [ADDR_W-1:0]   Out_Count,
  input  logic [SAMPLE_W-1:0] Mem_Sample,
`ifdef LPC_READER_STALL_EN
  input  logic                Out_Ready,
`endif
  output logic                Pair_Valid,
  output logic [SAMPLE_W-1:0] Sample_A,
  output logic [SAMPLE_W-1:0] Sample_B,
  output logic                Busy,
  output logic                Done
);

  rd_state_e           state;
  logic [CALC_W-1:0]   n_q;
  logic [CALC_W-1:0]   k_q;
  logic [CALC_W-1:0]   last_n_q;
  logic [ADDR_W-1:0]   out_count_q;
  logic                busy_q;
  logic                rd_a_q;
  logic                rd_b_q;
  logic [SAMPLE_W-1:0] a_q;

  logic                pair_valid;
  logic [SAMPLE_W-1:0] pair_a;
  logic [SAMPLE_W-1:0] pair_b;
  logic                can_issue;
  logic                can_resume;
  logic                last_accept;

`ifdef LPC_READER_STALL_EN
  logic     rd_b_last_q;
  logic     hold_valid;
  rd_pair_t pair_in;
  rd_pair_t pair_out;

  assign pair_in = '{a: a_q, b: Mem_Sample, last: rd_b_last_q};

  lpc_rd_skid u_skid (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (rd_b_q),
    .in_pair    (pair_in),
    .out_ready  (Out_Ready),
    .out_valid  (pair_valid),
    .out_pair   (pair_out),
    .hold_valid (hold_valid)
  );

  assign pair_a      = pair_out.a;
  assign pair_b      = pair_out.b;
  // A new pair may only be started once the skid is guaranteed to be empty after this edge.
  assign can_issue   = !hold_valid && (!pair_valid || Out_Ready);
  assign can_resume  = can_issue && !rd_b_q;
  assign last_accept = pair_valid && pair_out.last && Out_Ready;
  assign Done        = (state == ST_DONE) && last_accept;
`else
  logic                done_q;
  logic [SAMPLE_W-1:0] sample_a_q;
  logic [SAMPLE_W-1:0] sample_b_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pair_valid <= 1'b0;
      sample_a_q <= '0;
      sample_b_q <= '0;
    end else begin
      pair_valid <= rd_b_q;
      if (rd_b_q) begin
        sample_a_q <= a_q;
        sample_b_q <= Mem_Sample;
      end
    end
  end

  assign pair_a      = sample_a_q;
  assign pair_b      = sample_b_q;
  assign can_issue   = 1'b1;
  assign can_resume  = 1'b1;
  assign last_accept = 1'b1;
  assign Done        = done_q;
`endif

  // NOTE: every register here updates with <= so all state moves on the
  // same edge regardless of statement order inside the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      last_n_q    <= '0;
      out_count_q <= '0;
      busy_q      <= 1'b0;
      rd_a_q      <= 1'b0;
      rd_b_q      <= 1'b0;
      a_q         <= '0;
`ifdef LPC_READER_STALL_EN
      rd_b_last_q <= 1'b0;
`else
      done_q      <= 1'b0;
`endif
    end else begin
      // Read data returns one cycle after the address, so the issuing state is delayed by one.
      rd_a_q <= (state == ST_RD_A);
      rd_b_q <= (state == ST_RD_B);
`ifdef LPC_READER_STALL_EN
      rd_b_last_q <= (state == ST_RD_B) && (n_q == last_n_q);
`else
      done_q <= 1'b0;
`endif
      if (rd_a_q) begin
        a_q <= Mem_Sample;
      end

      case (state)
        ST_IDLE: begin
          out_count_q <= '0;
          if (Start) begin
            k_q      <= CALC_W'(Lag);
            last_n_q <= CALC_W'(L_WINDOW - 1) - CALC_W'(Lag);
            n_q      <= '0;
            busy_q   <= 1'b1;
            state    <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          out_count_q <= to_addr(n_q + k_q);
          state       <= ST_RD_B;
        end
        ST_RD_B: begin
          if (n_q == last_n_q) begin
            out_count_q <= '0;
            state       <= ST_DRAIN;
          end else begin
            n_q <= n_q + CALC_W'(1);
            if (can_issue) begin
              out_count_q <= to_addr(n_q + CALC_W'(1));
              state       <= ST_RD_A;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (can_resume) begin
            out_count_q <= to_addr(n_q);
            state       <= ST_RD_A;
          end
        end
        ST_DRAIN: begin
          out_count_q <= '0;
          state       <= ST_DONE;
`ifndef LPC_READER_STALL_EN
          done_q      <= 1'b1;
`endif
        end
        ST_DONE: begin
          out_count_q <= '0;
          if (last_accept) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          out_count_q <= '0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign Out_Count  = out_count_q;
  assign Busy       = busy_q;
  assign Pair_Valid = pair_valid;
  assign Sample_A   = pair_a;
  assign Sample_B   = pair_b;

endmodule

// File: tb/tb_lpc_mem_reader.sv
// Directed bench for lpc_mem_reader against a buffer holding x[i] = i.
// The stall scenario runs only when LPC_READER_STALL_EN is defined.
module tb_lpc_mem_reader;

  localparam int L = 240;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  Lag;
  logic [7:0]  Out_Count;
  logic [15:0] Mem_Sample;
  logic        Pair_Valid;
  logic [15:0] Sample_A;
  logic [15:0] Sample_B;
  logic        Busy;
  logic        Done;
  logic        rdy;

  logic [15:0] mem [256];

  int passed = 0;
  int total  = 0;

  // Per-pass results filled in by run_pass
  int r_pairs, r_bad, r_max_oc, r_done_cycle, r_first_pv, r_busy_drop;
  int r_stall_cycles, r_unstable;
  bit r_done_with_pv;
  logic [15:0] r_last_a, r_last_b;
  logic r_busy_after, r_done_after;

  lpc_mem_reader #(.L_WINDOW(L), .LAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .Start      (Start),
    .Lag        (Lag),
    .Out_Count  (Out_Count),
    .Mem_Sample (Mem_Sample),
`ifdef LPC_READER_STALL_EN
    .Out_Ready  (rdy),
`endif
    .Pair_Valid (Pair_Valid),
    .Sample_A   (Sample_A),
    .Sample_B   (Sample_B),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 clock = ~clock;

  // Synchronous-read buffer model
  always @(posedge clock) Mem_Sample <= mem[Out_Count];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_pass(input int k, input int restart_at, input int stall_pair);
    int c;
    int stall_left;
    logic [15:0] ha, hb;
    ha = '0;
    hb = '0;
    r_pairs = 0; r_bad = 0; r_max_oc = 0; r_done_cycle = -1; r_first_pv = -1;
    r_busy_drop = 0; r_stall_cycles = 0; r_unstable = 0; r_done_with_pv = 0;
    r_last_a = 'x; r_last_b = 'x;
    stall_left = (stall_pair >= 0) ? 5 : 0;
    Lag = 4'(k);
    Start = 1'b1;
    step();
    c = 1;
    while (1) begin
      Start = (c == restart_at);
      if (c == restart_at) Lag = 4'd3;
      rdy = 1'b1;
      if (stall_left > 0 && Pair_Valid === 1'b1 && r_pairs == stall_pair) begin
        rdy = 1'b0;
        if (stall_left == 5) begin
          ha = Sample_A;
          hb = Sample_B;
        end else if (Sample_A !== ha || Sample_B !== hb) begin
          r_unstable++;
        end
        stall_left--;
        r_stall_cycles++;
      end
      #1;
      if (int'(Out_Count) > r_max_oc) r_max_oc = int'(Out_Count);
      if (Busy !== 1'b1) r_busy_drop++;
      if (Pair_Valid === 1'b1 && r_first_pv < 0) r_first_pv = c;
      if (Pair_Valid === 1'b1 && rdy) begin
        if (Sample_A !== 16'(r_pairs) || Sample_B !== 16'(r_pairs + k)) begin
          if (r_bad == 0)
            $display("FAIL pair_value k=%0d pair %0d: got (%0d,%0d) expected (%0d,%0d)",
                     k, r_pairs, Sample_A, Sample_B, r_pairs, r_pairs + k);
          r_bad++;
        end
        r_last_a = Sample_A;
        r_last_b = Sample_B;
        r_pairs++;
      end
      if (Done === 1'b1) begin
        r_done_cycle   = c;
        r_done_with_pv = (Pair_Valid === 1'b1) && rdy;
      end
      if (r_done_cycle >= 0 || c >= 1500) break;
      c++;
      step();
    end
    Start = 1'b0;
    rdy = 1'b1;
    step();
    r_busy_after = Busy;
    r_done_after = Done;
    if (r_done_cycle < 0) begin
      // Recover from a hung pass so later scenarios still run
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Lag = 4'd0; rdy = 1'b1;
    repeat (3) step();
    total++;
    if ({Out_Count, Pair_Valid, Sample_A, Sample_B, Busy, Done} !== '0)
      $display("FAIL reset_outputs: got oc=%0d pv=%b a=%0d b=%0d busy=%b done=%b expected all 0",
               Out_Count, Pair_Valid, Sample_A, Sample_B, Busy, Done);
    else passed++;
    Start = 1'b1;
    step();
    reset = 1'b0; Start = 1'b0;
    step();
    total++;
    if (Busy !== 1'b0) $display("FAIL start_during_reset: Busy got %b expected 0", Busy);
    else passed++;
    total++;
    if (Out_Count !== 8'd0) $display("FAIL idle_out_count: got %0d expected 0", Out_Count);
    else passed++;
  endtask

  task automatic test_k0();
    run_pass(0, -1, -1);
    total++;
    if (r_pairs !== 240) $display("FAIL k0_pair_count: got %0d expected 240", r_pairs);
    else passed++;
    total++;
    if (r_bad !== 0) $display("FAIL k0_pair_values: got %0d bad pairs expected 0", r_bad);
    else passed++;
    total++;
    if (r_done_cycle !== 482) $display("FAIL k0_done_cycle: got %0d expected 482", r_done_cycle);
    else passed++;
    total++;
    if (r_done_with_pv !== 1'b1) $display("FAIL k0_done_with_last: got %b expected 1", r_done_with_pv);
    else passed++;
    total++;
    if (r_busy_after !== 1'b0 || r_done_after !== 1'b0)
      $display("FAIL k0_after_done: got busy=%b done=%b expected 0 0", r_busy_after, r_done_after);
    else passed++;
    total++;
    if (r_busy_drop !== 0) $display("FAIL k0_busy_held: got %0d low cycles expected 0", r_busy_drop);
    else passed++;
  endtask

  task automatic test_k10();
    run_pass(10, -1, -1);
    total++;
    if (r_pairs !== 230) $display("FAIL k10_pair_count: got %0d expected 230", r_pairs);
    else passed++;
    total++;
    if (r_bad !== 0) $display("FAIL k10_pair_values: got %0d bad pairs expected 0", r_bad);
    else passed++;
    total++;
    if (r_last_a !== 16'd229 || r_last_b !== 16'd239)
      $display("FAIL k10_last_pair: got (%0d,%0d) expected (229,239)", r_last_a, r_last_b);
    else passed++;
    total++;
    if (r_max_oc !== 239) $display("FAIL k10_max_out_count: got %0d expected 239", r_max_oc);
    else passed++;
    total++;
    if (r_done_cycle !== 462 || r_done_with_pv !== 1'b1)
      $display("FAIL k10_done: got cycle %0d with_pair %b expected 462 1", r_done_cycle, r_done_with_pv);
    else passed++;
  endtask

  task automatic test_latency();
    int guard;
    Lag = 4'd10;
    Start = 1'b1;
    step();
    Start = 1'b0;
    total++;
    if (Out_Count !== 8'd0 || Busy !== 1'b1)
      $display("FAIL lat_cycle1: got oc=%0d busy=%b expected 0 1", Out_Count, Busy);
    else passed++;
    step();
    total++;
    if (Out_Count !== 8'd10) $display("FAIL lat_cycle2: got oc=%0d expected 10", Out_Count);
    else passed++;
    step();
    total++;
    if (Pair_Valid !== 1'b0) $display("FAIL lat_cycle3: got pv=%b expected 0", Pair_Valid);
    else passed++;
    step();
    total++;
    if (Pair_Valid !== 1'b1 || Sample_A !== 16'd0 || Sample_B !== 16'd10)
      $display("FAIL lat_cycle4: got pv=%b a=%0d b=%0d expected 1 0 10", Pair_Valid, Sample_A, Sample_B);
    else passed++;
    step();
    total++;
    if (Pair_Valid !== 1'b0) $display("FAIL lat_cycle5: got pv=%b expected 0", Pair_Valid);
    else passed++;
    guard = 0;
    while (Busy === 1'b1 && guard < 1000) begin
      step();
      guard++;
    end
    total++;
    if (Busy !== 1'b0) $display("FAIL lat_pass_end: Busy got %b expected 0 within budget", Busy);
    else passed++;
    step();
  endtask

  task automatic test_restart_ignored();
    run_pass(10, 50, -1);
    total++;
    if (r_pairs !== 230 || r_bad !== 0)
      $display("FAIL restart_pairs: got %0d pairs %0d bad expected 230 0", r_pairs, r_bad);
    else passed++;
    total++;
    if (r_done_cycle !== 462) $display("FAIL restart_done_cycle: got %0d expected 462", r_done_cycle);
    else passed++;
    step();
    total++;
    if (Busy !== 1'b0) $display("FAIL restart_no_new_pass: Busy got %b expected 0", Busy);
    else passed++;
  endtask

  task automatic test_reset_mid_pass();
    int events;
    Lag = 4'd5;
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({Out_Count, Pair_Valid, Sample_A, Sample_B, Busy, Done} !== '0)
      $display("FAIL midreset_outputs: got oc=%0d pv=%b a=%0d b=%0d busy=%b done=%b expected all 0",
               Out_Count, Pair_Valid, Sample_A, Sample_B, Busy, Done);
    else passed++;
    events = 0;
    repeat (40) begin
      step();
      if (Pair_Valid !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) events++;
    end
    total++;
    if (events !== 0) $display("FAIL midreset_quiet: got %0d active cycles expected 0", events);
    else passed++;
    run_pass(0, -1, -1);
    total++;
    if (r_pairs !== 240 || r_bad !== 0 || r_done_with_pv !== 1'b1)
      $display("FAIL midreset_next_pass: got %0d pairs %0d bad done_with_last %b expected 240 0 1",
               r_pairs, r_bad, r_done_with_pv);
    else passed++;
  endtask

`ifdef LPC_READER_STALL_EN
  task automatic test_stall();
    run_pass(10, -1, 3);
    total++;
    if (r_stall_cycles !== 5) $display("FAIL stall_cycles: got %0d expected 5", r_stall_cycles);
    else passed++;
    total++;
    if (r_unstable !== 0) $display("FAIL stall_pair_held: got %0d changes expected 0", r_unstable);
    else passed++;
    total++;
    if (r_pairs !== 230 || r_bad !== 0)
      $display("FAIL stall_pairs: got %0d pairs %0d bad expected 230 0", r_pairs, r_bad);
    else passed++;
    total++;
    if (r_last_a !== 16'd229 || r_last_b !== 16'd239 || r_done_with_pv !== 1'b1)
      $display("FAIL stall_last: got (%0d,%0d) done_with_last %b expected (229,239) 1",
               r_last_a, r_last_b, r_done_with_pv);
    else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    test_reset();
    test_latency();
    test_k0();
    test_k10();
    test_restart_ignored();
    test_reset_mid_pass();
`ifdef LPC_READER_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
